eda_neighbor_fifo_bank: RTL and testbench
=========================================

Name: eda_neighbor_fifo_bank

Overview:
- Bank of WINDOW_WIDTH-1 (default 8) first-word-fall-through FIFOs, one per 3x3 neighbour direction.
- Holds neighbour pixel addresses that are still pending during regional-max flood expansion.
- Sits directly downstream of the window comparator and feeds the region controller.
  - Input side: takes the centre address and a neighbour-position mask, and pushes each selected neighbour's {row,col} into its direction FIFO.
  - Output side: returns the per-FIFO empty vector and the head address of the FIFO picked by the controller's one-hot read_en.

Parameters:
- WINDOW_WIDTH, 9 (`CFG_WINDOW_WIDTH): 3x3 window size; number of FIFOs = WINDOW_WIDTH-1.
- I_WIDTH, 8 (`CFG_I_WIDTH): row index width.
- J_WIDTH, 8 (`CFG_J_WIDTH): column index width.
- ADDR_WIDTH, 16 (`CFG_ADDR_WIDTH): equals I_WIDTH+J_WIDTH; address = {row,col}.
- FIFO_DEPTH, 16: entries per FIFO; must be a power of 2, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of all FIFOs and of the overflow flag.
- push_en  in  1  push strobe.
- push_positions  in  WINDOW_WIDTH-1  neighbour mask; bit k selects direction k.
- center_addr  in  ADDR_WIDTH  {row,col} of the current centre pixel.
- img_rows  in  I_WIDTH  image height (≥1).
- img_cols  in  J_WIDTH  image width (≥1).
- read_en  in  WINDOW_WIDTH-1  one-hot pop select (zero = no pop).
- fifo_empty  out  WINDOW_WIDTH-1  per-FIFO empty flag, registered.
- fifo_full  out  WINDOW_WIDTH-1  per-FIFO full flag, registered.
- data_out  out  ADDR_WIDTH  head of the FIFO selected by read_en; 0 if none selected or the selected FIFO is empty.
- overflow  out  1  sticky: a push was dropped because its FIFO was full.

Behaviour:
- Reset (reset=1 at a clock edge):
  - All pointers and counts = 0.
  - fifo_empty = all ones; fifo_full = 0; overflow = 0; data_out = 0.
  - Reset has priority over every other input. Asserting it mid-operation discards all content.
- Clear: same effect as reset on pointers, flags and overflow, one cycle. Priority over push/pop in the same cycle.
- Direction map, bit k → (dr,dc):
  - 0 (-1,-1), 1 (-1,0), 2 (-1,+1)
  - 3 (0,-1), 4 (0,+1)
  - 5 (+1,-1), 6 (+1,0), 7 (+1,+1)
- Neighbour address = {row+dr, col+dc}, computed in I_WIDTH/J_WIDTH arithmetic.
- Boundary masking (applied before push; masked bits are never pushed and never set overflow):
  - row==0 masks bits 0,1,2.
  - row==img_rows-1 masks bits 5,6,7.
  - col==0 masks bits 0,3,5.
  - col==img_cols-1 masks bits 2,4,7.
  - 1x1 image masks all bits.
- Push:
  - In a cycle with push_en=1, each unmasked bit k writes its address into FIFO k. All eight can be written in the same cycle.
  - Latency: pushed in cycle N → fifo_empty[k]=0 and data is poppable in cycle N+1.
- Pop:
  - When read_en[k]=1 and fifo_empty[k]=0, data_out shows the head of FIFO k combinationally in the same cycle.
  - The head is removed at the clock edge.
  - read_en with more than one bit set is illegal. The RTL uses the lowest set bit; assertion in simulation.
  - Pop of an empty FIFO is ignored (no pointer change).
- Simultaneous push and pop on the same FIFO:
  - Not full: both take effect; count unchanged.
  - Full: pop and push both succeed, no overflow.
  - Empty: pop ignored, push succeeds.
- Push to a full FIFO without a same-cycle pop: entry dropped, overflow ← 1 (sticky until reset/clear).
- Wrap-around: pointers are log2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and the remaining bits are equal; empty when all bits are equal. Wrap is transparent to ordering.
- fifo_empty/fifo_full are derived from the next-state pointers and registered, so there is no combinational path from push_en to fifo_empty.
- push_en=0: no writes regardless of push_positions.

Optional Feature:
- Macro: EDA_NBR_FIFO_STATS_EN.
- Defined:
  - Adds output port max_occupancy (log2(FIFO_DEPTH)+1 bits): the highest count reached by any FIFO since the last reset/clear.
  - Updated one cycle after the count changes; reset/clear → 0.
- Undefined: port and counters are absent; all other behaviour identical.

Test Plan:
- Reset, then idle 5 cycles → fifo_empty=8'hFF, fifo_full=0, overflow=0, data_out=0.
- center_addr={8'd5,8'd5}, img 10x10, push_en=1, push_positions=8'hFF:
  - next cycle fifo_empty=8'h00.
  - read_en=8'h01 gives data_out=16'h0404; read_en=8'h80 gives 16'h0606.
- center_addr={8'd0,8'd0}, push_positions=8'hFF → only FIFOs 4,6,7 filled: fifo_empty=8'h2F, overflow=0.
- 16 pushes of bit 1 (FIFO_DEPTH=16), distinct centres:
  - fifo_full[1]=1.
  - 17th push dropped, overflow=1.
  - 16 pops return the addresses in push order across pointer wrap.
- FIFO 3 holding 1 entry, same-cycle push bit 3 + read_en=8'h08:
  - old head popped; fifo_empty[3] stays 0; new entry is the next head.
- Mid-stream clear=1 with push_en=1 and read_en≠0 → next cycle all empty, overflow=0, nothing from that cycle's push retained.

Source files
------------

// File: rtl/eda_neighbor_fifo_bank.sv
// eda_neighbor_fifo_bank: one first-word-fall-through FIFO per 3x3 neighbour
// direction. It holds the neighbour addresses that a regional-max flood fill
// still has to visit.
// Optional build macro: EDA_NBR_FIFO_STATS_EN adds the max_occupancy output.

`ifndef CFG_WINDOW_WIDTH
`define CFG_WINDOW_WIDTH 9
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 8
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 8
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 16
`endif

module eda_neighbor_fifo_bank #(
    parameter int unsigned WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
    parameter int unsigned I_WIDTH      = `CFG_I_WIDTH,
    parameter int unsigned J_WIDTH      = `CFG_J_WIDTH,
    parameter int unsigned ADDR_WIDTH   = `CFG_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      push_en,
    input  logic [WINDOW_WIDTH-2:0]   push_positions,
    input  logic [ADDR_WIDTH-1:0]     center_addr,
    input  logic [I_WIDTH-1:0]        img_rows,
    input  logic [J_WIDTH-1:0]        img_cols,
    input  logic [WINDOW_WIDTH-2:0]   read_en,
    output logic [WINDOW_WIDTH-2:0]   fifo_empty,
    output logic [WINDOW_WIDTH-2:0]   fifo_full,
    output logic [ADDR_WIDTH-1:0]     data_out,
    output logic                      overflow
`ifdef EDA_NBR_FIFO_STATS_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] max_occupancy
`endif
);

    localparam int unsigned NF    = WINDOW_WIDTH - 1;
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [ADDR_WIDTH-1:0] mem_q [NF][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NF];
    logic [PTR_W-1:0]      wr_ptr_d [NF];
    logic [PTR_W-1:0]      rd_ptr_q [NF];
    logic [PTR_W-1:0]      rd_ptr_d [NF];
    logic [NF-1:0]         fifo_empty_q, fifo_empty_d;
    logic [NF-1:0]         fifo_full_q, fifo_full_d;
    logic                  overflow_q, overflow_d;

    logic [I_WIDTH-1:0]    row, row_m1, row_p1;
    logic [J_WIDTH-1:0]    col, col_m1, col_p1;
    logic [ADDR_WIDTH-1:0] nbr_addr [NF];
    logic [NF-1:0]         bnd_mask;
    logic [NF-1:0]         push_mask;
    logic [NF-1:0]         pop_sel;
    logic [NF-1:0]         pop_v;
    logic [NF-1:0]         push_v;
    logic [NF-1:0]         drop_v;

    // Neighbour addresses and the image-boundary mask for the current centre
    always_comb begin
        row    = center_addr[ADDR_WIDTH-1:J_WIDTH];
        col    = center_addr[J_WIDTH-1:0];
        row_m1 = row - I_WIDTH'(1);
        row_p1 = row + I_WIDTH'(1);
        col_m1 = col - J_WIDTH'(1);
        col_p1 = col + J_WIDTH'(1);

        nbr_addr[0] = {row_m1, col_m1};
        nbr_addr[1] = {row_m1, col};
        nbr_addr[2] = {row_m1, col_p1};
        nbr_addr[3] = {row,    col_m1};
        nbr_addr[4] = {row,    col_p1};
        nbr_addr[5] = {row_p1, col_m1};
        nbr_addr[6] = {row_p1, col};
        nbr_addr[7] = {row_p1, col_p1};

        bnd_mask = '0;
        if (row == '0)
            bnd_mask = bnd_mask | NF'(8'b0000_0111);
        if (row == I_WIDTH'(img_rows - I_WIDTH'(1)))
            bnd_mask = bnd_mask | NF'(8'b1110_0000);
        if (col == '0)
            bnd_mask = bnd_mask | NF'(8'b0010_1001);
        if (col == J_WIDTH'(img_cols - J_WIDTH'(1)))
            bnd_mask = bnd_mask | NF'(8'b1001_0100);

        push_mask = push_en ? (push_positions & ~bnd_mask) : '0;
        // Lowest set bit wins if read_en is ever multi-hot
        pop_sel   = read_en & (~read_en + NF'(1));
    end

    // Pointer, flag and overflow next-state; clear overrides push and pop
    always_comb begin
        pop_v        = '0;
        push_v       = '0;
        drop_v       = '0;
        fifo_empty_d = fifo_empty_q;
        fifo_full_d  = fifo_full_q;
        overflow_d   = overflow_q;
        for (int k = 0; k < int'(NF); k++) begin
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
        end

        for (int k = 0; k < int'(NF); k++) begin
            pop_v[k]  = pop_sel[k] & ~fifo_empty_q[k];
            push_v[k] = push_mask[k] & (~fifo_full_q[k] | pop_v[k]);
            drop_v[k] = push_mask[k] & fifo_full_q[k] & ~pop_v[k];
            wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(push_v[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(pop_v[k]);
            fifo_empty_d[k] = (wr_ptr_d[k] == rd_ptr_d[k]);
            fifo_full_d[k]  = (wr_ptr_d[k][PTR_W-1] != rd_ptr_d[k][PTR_W-1]) &&
                              (wr_ptr_d[k][IDX_W-1:0] == rd_ptr_d[k][IDX_W-1:0]);
        end
        overflow_d = overflow_q | (|drop_v);

        if (clear) begin
            for (int k = 0; k < int'(NF); k++) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
            end
            fifo_empty_d = '1;
            fifo_full_d  = '0;
            overflow_d   = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(NF); k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
            fifo_empty_q <= '1;
            fifo_full_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            for (int k = 0; k < int'(NF); k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
            end
            fifo_empty_q <= fifo_empty_d;
            fifo_full_q  <= fifo_full_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NF); k++) begin
            if (!reset && !clear && push_v[k])
                mem_q[k][wr_ptr_q[k][IDX_W-1:0]] <= nbr_addr[k];
        end
    end

    // Fall-through head of the selected FIFO, zero when none or empty
    always_comb begin
        data_out = '0;
        for (int k = 0; k < int'(NF); k++) begin
            if (pop_sel[k] && !fifo_empty_q[k])
                data_out = mem_q[k][rd_ptr_q[k][IDX_W-1:0]];
        end
    end

    assign fifo_empty = fifo_empty_q;
    assign fifo_full  = fifo_full_q;
    assign overflow   = overflow_q;

`ifdef EDA_NBR_FIFO_STATS_EN
    logic [PTR_W-1:0] max_occ_q, max_occ_d;

    // Running maximum of per-FIFO occupancy, lagging the count by one cycle
    always_comb begin
        logic [PTR_W-1:0] occ;
        occ       = '0;
        max_occ_d = max_occ_q;
        for (int k = 0; k < int'(NF); k++) begin
            occ = wr_ptr_q[k] - rd_ptr_q[k];
            if (occ > max_occ_d)
                max_occ_d = occ;
        end
        if (clear)
            max_occ_d = '0;
    end

    // Occupancy statistic register
    always_ff @(posedge clk) begin
        if (reset)
            max_occ_q <= '0;
        else
            max_occ_q <= max_occ_d;
    end

    assign max_occupancy = max_occ_q;
`endif

    // read_en must be one-hot or zero
    assert property (@(posedge clk) disable iff (reset) $onehot0(read_en))
        else $error("eda_neighbor_fifo_bank: read_en is multi-hot");

endmodule

// File: tb/tb_eda_neighbor_fifo_bank.sv
// Scoreboard bench for eda_neighbor_fifo_bank: a queue-based reference model
// predicts each cycle's outputs, and a monitor compares them against the DUT.

module tb_eda_neighbor_fifo_bank;

    localparam int DEPTH = 16;
    localparam int DR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    localparam int DC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        push_en = 1'b0;
    logic [7:0]  push_positions = '0;
    logic [15:0] center_addr = '0;
    logic [7:0]  img_rows = 8'd10;
    logic [7:0]  img_cols = 8'd10;
    logic [7:0]  read_en = '0;
    logic [7:0]  fifo_empty;
    logic [7:0]  fifo_full;
    logic [15:0] data_out;
    logic        overflow;
`ifdef EDA_NBR_FIFO_STATS_EN
    logic [4:0]  max_occupancy;
`endif

    eda_neighbor_fifo_bank dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .push_en        (push_en),
        .push_positions (push_positions),
        .center_addr    (center_addr),
        .img_rows       (img_rows),
        .img_cols       (img_cols),
        .read_en        (read_en),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .data_out       (data_out),
`ifdef EDA_NBR_FIFO_STATS_EN
        .max_occupancy  (max_occupancy),
`endif
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  empty;
        logic [7:0]  full;
        logic        ovf;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] mq [8][$];
    logic        m_ovf = 1'b0;
    logic        m_valid = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    endtask

    // Reference model: one bounded queue per direction, bounds checked in plain integers
    task automatic model_step(input logic rst, input logic clr, input logic pe,
                              input logic [7:0] pp, input logic [15:0] ca,
                              input logic [7:0] rr, input logic [7:0] cc,
                              input logic [7:0] re);
        int r, c, nr, nc;
        logic [15:0] tmp;
        if (rst || clr) begin
            for (int k = 0; k < 8; k++) mq[k].delete();
            m_ovf = 1'b0;
            return;
        end
        for (int k = 0; k < 8; k++)
            if (re[k] && mq[k].size() > 0) tmp = mq[k].pop_front();
        r = int'(ca[15:8]);
        c = int'(ca[7:0]);
        if (pe) begin
            for (int k = 0; k < 8; k++) begin
                nr = r + DR[k];
                nc = c + DC[k];
                if (pp[k] && nr >= 0 && nr < int'(rr) && nc >= 0 && nc < int'(cc)) begin
                    if (mq[k].size() < DEPTH) mq[k].push_back({nr[7:0], nc[7:0]});
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle, queue the model's prediction, then advance the model
    task automatic cycle(input logic rst, input logic clr, input logic pe,
                         input logic [7:0] pp, input logic [15:0] ca,
                         input logic [7:0] rr, input logic [7:0] cc,
                         input logic [7:0] re);
        exp_t e;
        @(negedge clk);
        reset = rst; clear = clr; push_en = pe; push_positions = pp;
        center_addr = ca; img_rows = rr; img_cols = cc; read_en = re;
        if (m_valid) begin
            e.data = '0;
            for (int k = 0; k < 8; k++) begin
                e.empty[k] = (mq[k].size() == 0);
                e.full[k]  = (mq[k].size() == DEPTH);
                if (re[k] && mq[k].size() > 0) e.data = mq[k][0];
            end
            e.ovf = m_ovf;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        model_step(rst, clr, pe, pp, ca, rr, cc, re);
        if (rst) m_valid = 1'b1;
        cyc++;
    endtask

    task automatic idle(input logic [7:0] re);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'd10, 8'd10, re);
    endtask

    // Monitor: compare whatever the scoreboard holds against presented outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("empty@%0d", e.cyc), 16'(fifo_empty), 16'(e.empty));
                chk($sformatf("full@%0d", e.cyc), 16'(fifo_full), 16'(e.full));
                chk($sformatf("ovf@%0d", e.cyc), 16'(overflow), 16'(e.ovf));
                chk($sformatf("data@%0d", e.cyc), data_out, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rr, cc, rw, cl, re;
        // Reset then idle
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8'd10, 8'd10, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8'd10, 8'd10, 8'h00);
        for (int i = 0; i < 5; i++) idle(8'h00);
        #2;
        chk("rst_empty", 16'(fifo_empty), 16'h00FF);
        chk("rst_full", 16'(fifo_full), 16'h0000);
        chk("rst_ovf", 16'(overflow), 16'h0000);
        chk("rst_data", data_out, 16'h0000);

        // Interior centre (5,5), all eight neighbours
        cycle(1'b0, 1'b0, 1'b1, 8'hFF, {8'd5, 8'd5}, 8'd10, 8'd10, 8'h00);
        idle(8'h01);
        #2;
        chk("c55_empty", 16'(fifo_empty), 16'h0000);
        chk("c55_dir0", data_out, 16'h0404);
        idle(8'h80);
        #2;
        chk("c55_dir7", data_out, 16'h0606);

        // Corner centre (0,0): only directions 4, 6, 7 survive
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'd10, 8'd10, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'hFF, {8'd0, 8'd0}, 8'd10, 8'd10, 8'h00);
        idle(8'h00);
        #2;
        chk("c00_empty", 16'(fifo_empty), 16'h002F);
        chk("c00_ovf", 16'(overflow), 16'h0000);

        // Fill FIFO 1 across pointer wrap, then overflow
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'd32, 8'd32, 8'h00);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 1'b1, 8'h02, {8'(i + 1), 8'd3}, 8'd32, 8'd32, 8'h00);
        for (int i = 0; i < 5; i++) idle(8'h02);
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 1'b0, 1'b1, 8'h02, {8'(i + 1), 8'd4}, 8'd32, 8'd32, 8'h00);
        idle(8'h00);
        #2;
        chk("full1", 16'(fifo_full[1]), 16'h0001);
        chk("full1_noovf", 16'(overflow), 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 8'h02, {8'd20, 8'd4}, 8'd32, 8'd32, 8'h00);
        idle(8'h00);
        #2;
        chk("ovf_set", 16'(overflow), 16'h0001);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'd32, 8'd32, 8'h02);
            #2;
            chk($sformatf("wrap_pop%0d", i), data_out, {8'(i), 8'd4});
        end
        idle(8'h02);
        #2;
        chk("wrap_drained", data_out, 16'h0000);

        // Clear mid-stream with push and pop active
        cycle(1'b0, 1'b0, 1'b1, 8'hFF, {8'd5, 8'd5}, 8'd10, 8'd10, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'hFF, {8'd6, 8'd6}, 8'd10, 8'd10, 8'h01);
        idle(8'h01);
        #2;
        chk("clr_empty", 16'(fifo_empty), 16'h00FF);
        chk("clr_ovf", 16'(overflow), 16'h0000);
        chk("clr_data", data_out, 16'h0000);

        // FIFO 3 same-cycle push and pop
        cycle(1'b0, 1'b0, 1'b1, 8'h08, {8'd5, 8'd5}, 8'd10, 8'd10, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h08, {8'd7, 8'd7}, 8'd10, 8'd10, 8'h08);
        #2;
        chk("pp3_old", data_out, 16'h0504);
        idle(8'h08);
        #2;
        chk("pp3_notempty", 16'(fifo_empty[3]), 16'h0000);
        chk("pp3_new", data_out, 16'h0706);
        idle(8'h00);

        // Randomised traffic including small images, clears and resets
        for (int i = 0; i < 800; i++) begin
            rr = 8'($urandom_range(1, 12));
            cc = 8'($urandom_range(1, 12));
            if ($urandom_range(0, 15) == 0) begin rr = 8'd1; cc = 8'd1; end
            rw = 8'($urandom_range(0, int'(rr) - 1));
            cl = 8'($urandom_range(0, int'(cc) - 1));
            re = ($urandom_range(0, 9) < 6) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 9) < 7), 8'($urandom), {rw, cl}, rr, cc, re);
        end
        for (int i = 0; i < 3; i++) idle(8'h00);
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
